// File: rtl/adder_arb_pkg.sv
// Shared constants and the result-buffer record for the adder-sharing arbiter.
package adder_arb_pkg;

    localparam int ADD_WIDTH   = 32;
    localparam int DEF_NUM_REQ = 4;
    // Wide enough for the largest legal requester count (16).
    localparam int MAX_ID_W    = 4;

    typedef struct packed {
        logic [ADD_WIDTH-1:0] sum;
        logic                 cout;
        logic [MAX_ID_W-1:0]  id;
    } add_res_t;

endpackage

// File: rtl/kogge_stone_32.sv
// 32-bit Kogge-Stone parallel-prefix adder, carry-in fixed at zero.
module kogge_stone_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [31:0] w_gn;
    logic [31:0] w_pn;
    logic [31:0] w_p0;

    // Five prefix stages at spans 1,2,4,8,16 give group generate from bit 0.
    always_comb begin
        w_g  = a & b;
        w_p  = a ^ b;
        w_p0 = a ^ b;
        w_gn = 32'h0000_0000;
        w_pn = 32'h0000_0000;
        for (int s = 0; s < 5; s++) begin
            w_gn = w_g;
            w_pn = w_p;
            for (int i = (1 << s); i < 32; i++) begin
                w_gn[i] = w_g[i] | (w_p[i] & w_g[i - (1 << s)]);
                w_pn[i] = w_p[i] & w_p[i - (1 << s)];
            end
            w_g = w_gn;
            w_p = w_pn;
        end
        sum  = w_p0 ^ {w_g[30:0], 1'b0};
        cout = w_g[31];
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin request arbiter; define ADDARB_FIXED_PRIO_EN for lowest-index-wins priority.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    input  logic          i_enable,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx
);

    logic [IW-1:0] w_sel;
    logic [IW-1:0] w_j;
    logic [IW:0]   w_jsum;
    logic          w_found;

    // Scan candidates from the highest search offset down so the lowest offset wins.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_j     = '0;
        w_jsum  = '0;
        for (int k = N - 1; k >= 0; k--) begin
`ifdef ADDARB_FIXED_PRIO_EN
            w_jsum = (IW+1)'(k);
`else
            w_jsum = {1'b0, i_ptr} + (IW+1)'(k);
            w_jsum = (w_jsum >= (IW+1)'(N)) ? (w_jsum - (IW+1)'(N)) : w_jsum;
`endif
            w_j     = w_jsum[IW-1:0];
            w_found = w_found | i_req[w_j];
            w_sel   = i_req[w_j] ? w_j : w_sel;
        end
    end

    assign o_grant = (i_enable & w_found) ? ({{(N-1){1'b0}}, 1'b1} << w_sel) : {N{1'b0}};
    assign o_idx   = w_sel;

endmodule

// File: rtl/adder_share_arb.sv
// Shares one Kogge-Stone adder among NUM_REQ requesters with a one-entry result buffer.
// Build option: ADDARB_FIXED_PRIO_EN selects fixed priority and removes the round-robin pointer.
module adder_share_arb
    import adder_arb_pkg::*;
#(
    parameter int  NUM_REQ = DEF_NUM_REQ,
    parameter int  WIDTH   = ADD_WIDTH,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_sum,
    output logic                     res_cout,
    output logic [ID_W-1:0]          res_id
);

    if (WIDTH != ADD_WIDTH) begin : g_bad_width
        $error("adder_share_arb: WIDTH must be 32 to match kogge_stone_32");
    end
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("adder_share_arb: NUM_REQ must be in 2..16");
    end

    logic               w_can_accept;
    logic               w_arb_en;
    logic               w_xfer;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic [ID_W-1:0]    w_rr_ptr;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic               w_id_unused;
    add_res_t           r_res;
    logic               r_res_valid;

    assign w_can_accept = ~r_res_valid | res_ready;
    // Grants are suppressed while reset is asserted, not just after the first edge.
    assign w_arb_en     = w_can_accept & rst_n;
    assign w_xfer       = |(req_valid & w_grant);
    assign req_ready    = w_grant;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .i_req    (req_valid),
        .i_ptr    (w_rr_ptr),
        .i_enable (w_arb_en),
        .o_grant  (w_grant),
        .o_idx    (w_idx)
    );

    assign w_a = req_a[w_idx*WIDTH +: WIDTH];
    assign w_b = req_b[w_idx*WIDTH +: WIDTH];

    kogge_stone_32 u_add (
        .a    (w_a),
        .b    (w_b),
        .sum  (w_sum),
        .cout (w_cout)
    );

`ifdef ADDARB_FIXED_PRIO_EN
    assign w_rr_ptr = '0;
`else
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] w_ptr_nxt;

    assign w_ptr_nxt = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : (w_idx + ID_W'(1));
    assign w_rr_ptr  = r_rr_ptr;

    // Round-robin pointer moves past the winner only when a transfer happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_xfer) begin
            r_rr_ptr <= w_ptr_nxt;
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end
`endif

    // Result buffer: fill on transfer (also replaces a draining entry), clear on drain-only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res       <= '0;
            r_res_valid <= 1'b0;
        end else if (w_xfer) begin
            r_res       <= '{sum: w_sum, cout: w_cout, id: MAX_ID_W'(w_idx)};
            r_res_valid <= 1'b1;
        end else if (res_ready) begin
            r_res       <= r_res;
            r_res_valid <= 1'b0;
        end else begin
            r_res       <= r_res;
            r_res_valid <= r_res_valid;
        end
    end

    assign res_valid   = r_res_valid;
    assign res_sum     = r_res.sum;
    assign res_cout    = r_res.cout;
    assign res_id      = r_res.id[ID_W-1:0];
    assign w_id_unused = ^r_res.id;

endmodule

// File: tb/tb_adder_share_arb.sv
// Self-checking bench for adder_share_arb (default round-robin build, NUM_REQ=4).
module tb_adder_share_arb;

    localparam int N = 4;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*32-1:0]  req_a;
    logic [N*32-1:0]  req_b;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_sum;
    logic             res_cout;
    logic [1:0]       res_id;

    logic [31:0] ra [N];
    logic [31:0] rb [N];

    int n_tests;
    int n_fail;

    // Reference model of the result buffer and fairness pointer
    int          m_ptr;
    logic        m_valid;
    logic [31:0] m_sum;
    logic        m_cout;
    int          m_id;

    assign req_a = {ra[3], ra[2], ra[1], ra[0]};
    assign req_b = {rb[3], rb[2], rb[1], rb[0]};

    adder_share_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_sum   = 32'd0;
        m_cout  = 1'b0;
        m_id    = 0;
    endtask

    // Winner: first valid requester at or after the pointer, wrapping; -1 if none or buffer blocked.
    function automatic int exp_grant();
        int j;
        if (m_valid && !res_ready) return -1;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    // One clock: check grant, advance the model, then check the registered result.
    task automatic cycle(output int g);
        logic [32:0] full;
        #1;
        g = exp_grant();
        check("req_ready", 64'(req_ready), (g >= 0) ? 64'(4'b0001 << g) : 64'd0);
        if (g >= 0) begin
            full    = {1'b0, ra[g]} + {1'b0, rb[g]};
            m_sum   = full[31:0];
            m_cout  = full[32];
            m_id    = g;
            m_valid = 1'b1;
            m_ptr   = (g + 1) % N;
        end else if (res_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check("res_valid", 64'(res_valid), 64'(m_valid));
        check("res_sum",   64'(res_sum),   64'(m_sum));
        check("res_cout",  64'(res_cout),  64'(m_cout));
        check("res_id",    64'(res_id),    64'(m_id));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        res_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            ra[i] = 32'd0;
            rb[i] = 32'd0;
        end
        model_reset();

        // Reset state with requests pending
        #12;
        check("rst_valid", 64'(res_valid), 64'd0);
        check("rst_sum",   64'(res_sum),   64'd0);
        check("rst_cout",  64'(res_cout),  64'd0);
        check("rst_id",    64'(res_id),    64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);

        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        res_ready = 1'b1;

        // Single request on requester 0
        ra[0] = 32'h1233_ab71; rb[0] = 32'h0756_bdef; req_valid = 4'b0001;
        cycle(g);
        check("t1_grant", 64'(g), 64'd0);
        check("t1_sum",   64'(res_sum), 64'h198a_6960);
        check("t1_cout",  64'(res_cout), 64'd0);
        check("t1_id",    64'(res_id), 64'd0);

        // Carry-out cases on requester 2
        ra[2] = 32'hffde_1234; rb[2] = 32'hfede_ffd1; req_valid = 4'b0100;
        cycle(g);
        check("t2_sum",  64'(res_sum), 64'hfebd_1205);
        check("t2_cout", 64'(res_cout), 64'd1);
        check("t2_id",   64'(res_id), 64'd2);
        ra[2] = 32'hf3a1_565f; rb[2] = 32'h156a_1dfe;
        cycle(g);
        check("t3_sum",  64'(res_sum), 64'h090b_745d);
        check("t3_cout", 64'(res_cout), 64'd1);

        // Requester 3 alone wraps the pointer back to 0
        ra[3] = $urandom; rb[3] = $urandom; req_valid = 4'b1000;
        cycle(g);
        check("t4_id", 64'(res_id), 64'd3);

        // Full contention, no bubbles: ids 0,1,2,3,0
        for (int i = 0; i < N; i++) begin
            ra[i] = $urandom; rb[i] = $urandom;
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cycle(g);
            check("cont_id",    64'(res_id), 64'(k % N));
            check("cont_valid", 64'(res_valid), 64'd1);
        end

        // Backpressure: five stalled cycles, then resume at the held pointer (1)
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle(g);
            check("bp_nogrant", 64'(req_ready), 64'd0);
            check("bp_id",      64'(res_id), 64'd0);
        end
        res_ready = 1'b1;
        cycle(g);
        check("bp_resume", 64'(g), 64'd1);

        // Asynchronous reset while a result is buffered and requests pending
        res_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(res_valid), 64'd0);
        check("arst_ready", 64'(req_ready), 64'd0);
        check("arst_sum",   64'(res_sum),   64'd0);
        model_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        res_ready = 1'b1;
        req_valid = 4'b1010;
        cycle(g);
        check("arst_first", 64'(g), 64'd1);

        // Randomised traffic honouring the hold-until-accepted rule
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'($urandom_range(0, 1));
            ra[i] = $urandom; rb[i] = $urandom;
        end
        for (int it = 0; it < 300; it++) begin
            cycle(g);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || i == g) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    ra[i] = $urandom;
                    rb[i] = $urandom;
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Shares one combinational 32-bit adder (kogge_stone_32) among NUM_REQ requesters.
- Round-robin arbitration over per-requester valid/ready request channels.
- Registers the winning sum, carry-out and requester ID into a single-entry result buffer with a valid/ready output handshake.
- Sits between the adder datapath and its client blocks. It is the only path by which clients reach the adder.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- ID_W, $clog2(NUM_REQ), width of the result tag; derived, never overridden.
- WIDTH, 32, operand width; fixed to match kogge_stone_32, and elaboration fails on any other value.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*WIDTH  flattened operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  flattened operand B, same packing as req_a.
- res_valid  output  1  result buffer holds a valid entry.
- res_ready  input  1  consumer accepts the result.
- res_sum  output  WIDTH  registered sum, modulo 2^WIDTH.
- res_cout  output  1  registered carry-out of the addition.
- res_id  output  ID_W  index of the requester that produced the result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - res_valid=0, res_sum=0, res_cout=0, res_id=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready=0 while rst_n is low.
  - Any in-flight or buffered result is discarded.
  - Operation resumes on the first rising edge after rst_n deasserts.
- Buffer free: can_accept = !res_valid | res_ready. The buffer is free this cycle when empty or being drained.
- Grant (combinational):
  - When can_accept, grant the first i with req_valid[i], searching from rr_ptr upward with wrap-around.
  - req_ready[grant]=1; all other bits are 0.
  - No valid request, or !can_accept, gives req_ready=0.
- Transfer: occurs when req_valid[g] & req_ready[g].
- Operand mux: req_a/req_b of the granted requester feed the adder.
- Capture, on the next edge after a transfer:
  - res_sum <= sum, res_cout <= cout, res_id <= g, res_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
- Latency and throughput: 1 cycle from transfer to res_valid; 1 result per cycle sustained while res_ready=1.
- Simultaneous drain and fill: when res_valid & res_ready and a transfer occurs in the same cycle, the new result replaces the old one and res_valid stays 1.
- Drain only: when res_valid & res_ready with no transfer, res_valid <= 0 and the data registers hold their values.
- Backpressure: when res_valid & !res_ready, the result outputs are stable, req_ready=0 and rr_ptr holds.
- Requester protocol: a requester holds req_valid and its operands stable until accepted. The arbiter never revokes a grant mid-cycle because acceptance is same-cycle.
- rr_ptr advances only on a transfer. Idle cycles leave it unchanged.
- Starvation bound: any requester with req_valid held high is granted within NUM_REQ transfers.

Optional Feature:
- Macro: ADDARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest requester index wins, rr_ptr is removed (tied to 0) and the starvation bound is not guaranteed.
- Undefined (default): round-robin exactly as described under Behaviour.
- All other behaviour is identical in both builds.

Decomposition:
- Package adder_arb_pkg:
  - ADD_WIDTH=32 constant.
  - Default NUM_REQ.
  - Typedef add_res_t {sum, cout, id}, used for the result buffer register.
- Sub-module rr_arbiter:
  - Inputs: req, ptr, enable.
  - Outputs: one-hot grant and encoded index.
  - Contains the ADDARB_FIXED_PRIO_EN switch.
- Top level:
  - Instantiates rr_arbiter and kogge_stone_32 (a, b, sum, cout).
  - Owns the operand mux, result buffer and rr_ptr.

Test Plan:
- Single request: req0 a=32'h1233_ab71, b=32'h0756_bdef, res_ready=1 -> req_ready=4'b0001 that cycle; next cycle res_valid=1, res_sum=32'h198a_6960, res_cout=0, res_id=0.
- Carry-out: req2 a=32'hffde_1234, b=32'hfede_ffd1 -> res_sum=32'hfebd_1205, res_cout=1, res_id=2; also a=32'hf3a1_565f, b=32'h156a_1dfe -> res_sum=32'h090b_745d, res_cout=1.
- Contention: all four req_valid held high, res_ready=1, rr_ptr=0 -> res_id sequence 0,1,2,3,0 on consecutive cycles with no bubbles.
- Backpressure: res_valid=1, res_ready=0 for 5 cycles with all requests valid -> req_ready=0, res_* unchanged, rr_ptr unchanged; raising res_ready resumes grants at the held pointer.
- Reset mid-operation: pull rst_n low while res_valid=1 and requests are pending -> res_valid=0 and req_ready=0 immediately (asynchronous); after release the first grant goes to the lowest valid index, since rr_ptr=0.
- With ADDARB_FIXED_PRIO_EN: req0 and req3 held valid -> req0 granted every cycle and res_id=0 repeatedly.
